// File: rtl/score_pkg.sv
// Shared definitions for the leaderboard reader: default sizes, FSM states
// and the default rank-entry layout.
package score_pkg;

  localparam int unsigned DEF_NUM_PLAYERS = 5;
  localparam int unsigned DEF_SCORE_W     = 7;
  localparam int unsigned DEF_ID_W        = 3;
  localparam int unsigned RANKS           = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    DRAIN = 3'd2,
    EMIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic [DEF_ID_W-1:0]    id;
    logic [DEF_SCORE_W-1:0] score;
  } rank_entry_t;

endpackage

// File: rtl/score_reader_if.sv
// Score-store read port, scan request and leaderboard output stream of the
// score reader, bundled with reader-side (master) and environment-side (slave) views.
interface score_reader_if #(
  parameter int unsigned SCORE_W = score_pkg::DEF_SCORE_W,
  parameter int unsigned ID_W    = score_pkg::DEF_ID_W
);

  logic               Start;
  logic               Busy;
  logic               Rd_En;
  logic [ID_W-1:0]    Rd_Addr;
  logic [SCORE_W-1:0] Rd_Data;
  logic               Out_Valid;
  logic               Out_Ready;
  logic [1:0]         Out_Rank;
  logic [ID_W-1:0]    Out_ID;
  logic [SCORE_W-1:0] Out_Score;
  logic               Done;

  modport master (
    input  Start, Rd_Data, Out_Ready,
    output Busy, Rd_En, Rd_Addr, Out_Valid, Out_Rank, Out_ID, Out_Score, Done
  );

  modport slave (
    output Start, Rd_Data, Out_Ready,
    input  Busy, Rd_En, Rd_Addr, Out_Valid, Out_Rank, Out_ID, Out_Score, Done
  );

endinterface

// File: rtl/score_rank_insert.sv
// Combinational top-3 insertion: places a new (ID, score) ahead of the first
// slot that is empty or holds a strictly lower score, shifting the rest down.
module score_rank_insert import score_pkg::*; #(
  parameter type entry_t = rank_entry_t
) (
  input  logic                   en,
  input  entry_t [RANKS-1:0]     cur,
  input  logic   [RANKS-1:0]     cur_used,
  input  entry_t                 new_entry,
  output entry_t [RANKS-1:0]     nxt,
  output logic   [RANKS-1:0]     nxt_used
);

  int unsigned pos;
  logic        found;

  always_comb begin
    nxt      = cur;
    nxt_used = cur_used;
    found    = 1'b0;
    pos      = RANKS;

    // Strict compare: an equal score never displaces the earlier ID.
    for (int unsigned i = 0; i < RANKS; i++) begin
      if (!found && (!cur_used[i] || (new_entry.score > cur[i].score))) begin
        found = 1'b1;
        pos   = i;
      end
    end

    if (en && found) begin
      for (int unsigned i = 1; i < RANKS; i++) begin
        if (i > pos) begin
          nxt[i]      = cur[i-1];
          nxt_used[i] = cur_used[i-1];
        end
      end
      for (int unsigned i = 0; i < RANKS; i++) begin
        if (i == pos) begin
          nxt[i]      = new_entry;
          nxt_used[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/score_reader.sv
// Leaderboard reader: scans per-player best scores, keeps a running top-3 and
// streams it out by rank over a valid/ready handshake.
module score_reader import score_pkg::*; #(
  parameter int unsigned NUM_PLAYERS = DEF_NUM_PLAYERS,
  parameter int unsigned SCORE_W     = DEF_SCORE_W,
  parameter int unsigned ID_W        = DEF_ID_W
) (
  input  logic            Clk,
  input  logic            Reset,
  score_reader_if.master  bus
);

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [SCORE_W-1:0] score;
  } entry_t;

  localparam logic [ID_W-1:0] LAST_ADDR = ID_W'(NUM_PLAYERS - 1);

  state_t                 state_q, state_d;
  logic   [ID_W-1:0]      addr_q;
  logic   [1:0]           rank_q;
  logic                   pend_q;
  logic   [ID_W-1:0]      pend_id_q;
  entry_t [RANKS-1:0]     top_q, top_d;
  logic   [RANKS-1:0]     used_q, used_d;
  entry_t                 cap;
  logic                   start_acc;
  logic                   accept;

  assign start_acc = (state_q == IDLE) && bus.Start;
  assign accept    = (state_q == EMIT) && bus.Out_Ready;
  assign cap       = {pend_id_q, bus.Rd_Data};

  score_rank_insert #(
    .entry_t (entry_t)
  ) u_insert (
    .en        (pend_q),
    .cur       (top_q),
    .cur_used  (used_q),
    .new_entry (cap),
    .nxt       (top_d),
    .nxt_used  (used_d)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rank_q    <= '0;
      pend_q    <= 1'b0;
      pend_id_q <= '0;
      top_q     <= '0;
      used_q    <= '0;
    end else begin
      state_q   <= state_d;
      // Read data returns one cycle after the strobe; remember which address it belongs to.
      pend_q    <= (state_q == SCAN);
      pend_id_q <= (state_q == SCAN) ? addr_q : '0;
      if (start_acc) begin
        addr_q <= '0;
        rank_q <= '0;
        top_q  <= '0;
        used_q <= '0;
      end else begin
        if (pend_q) begin
          top_q  <= top_d;
          used_q <= used_d;
        end
        if (state_q == SCAN) begin
          addr_q <= (addr_q == LAST_ADDR) ? '0 : addr_q + ID_W'(1);
        end
        if (accept) begin
          rank_q <= (rank_q == 2'd2) ? 2'd0 : rank_q + 2'd1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.Start) state_d = SCAN;
      SCAN:    if (addr_q == LAST_ADDR) state_d = DRAIN;
      DRAIN:   state_d = EMIT;
      EMIT:    if (bus.Out_Ready && (rank_q == 2'd2)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.Busy      = (state_q != IDLE);
    bus.Rd_En     = (state_q == SCAN);
    bus.Rd_Addr   = addr_q;
    bus.Out_Valid = (state_q == EMIT);
    bus.Done      = (state_q == DONE);
    bus.Out_Rank  = '0;
    bus.Out_ID    = '0;
    bus.Out_Score = '0;
    if (state_q == EMIT) begin
      bus.Out_Rank  = rank_q;
      bus.Out_ID    = top_q[rank_q].id;
      bus.Out_Score = top_q[rank_q].score;
    end
  end

endmodule

// File: tb/tb_score_reader.sv
// Self-checking bench for score_reader: table vectors, handshake corner cases
// and randomized scans against a selection-sort leaderboard model.
module tb_score_reader;

  logic Clk = 1'b0;
  logic Reset;

  always #5 Clk = ~Clk;

  score_reader_if #(.SCORE_W(7), .ID_W(3)) bus ();

  score_reader #(
    .NUM_PLAYERS (5),
    .SCORE_W     (7),
    .ID_W        (3)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  logic [6:0] mem [8];
  int checks = 0;
  int errors = 0;

  // Score store: data for a strobed address appears one cycle later, junk otherwise.
  always @(posedge Clk) begin
    bus.Rd_Data <= bus.Rd_En ? mem[bus.Rd_Addr] : 7'($urandom);
  end

  typedef struct {
    int sc  [5];
    int eid [3];
    int esc [3];
    int mode;
    bit poke;
  } vec_t;

  vec_t vq [$];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic add_vec(input int s0, input int s1, input int s2, input int s3, input int s4,
                         input int i0, input int i1, input int i2,
                         input int c0, input int c1, input int c2,
                         input int mode, input bit poke);
    vec_t v;
    v.sc  = '{s0, s1, s2, s3, s4};
    v.eid = '{i0, i1, i2};
    v.esc = '{c0, c1, c2};
    v.mode = mode;
    v.poke = poke;
    vq.push_back(v);
  endtask

  // Leaderboard by repeated max selection; strict '>' keeps the lower ID on ties.
  task automatic model(output int eid [3], output int esc [3]);
    bit taken [5];
    int best;
    for (int i = 0; i < 5; i++) taken[i] = 1'b0;
    for (int r = 0; r < 3; r++) begin
      best = -1;
      for (int i = 0; i < 5; i++) begin
        if (!taken[i] && (best < 0 || int'(mem[i]) > int'(mem[best]))) best = i;
      end
      taken[best] = 1'b1;
      eid[r] = best;
      esc[r] = int'(mem[best]);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},  32'(bus.Busy), 0);
    chk({tag, "_rd_en"}, 32'(bus.Rd_En), 0);
    chk({tag, "_addr"},  32'(bus.Rd_Addr), 0);
    chk({tag, "_valid"}, 32'(bus.Out_Valid), 0);
    chk({tag, "_rank"},  32'(bus.Out_Rank), 0);
    chk({tag, "_id"},    32'(bus.Out_ID), 0);
    chk({tag, "_score"}, 32'(bus.Out_Score), 0);
    chk({tag, "_done"},  32'(bus.Done), 0);
  endtask

  // mode 0: always ready, 1: random ready, 2: stall rank 1 for four cycles.
  task automatic run_scan(input int mode, input bit poke, input int eid [3], input int esc [3]);
    int  n, c, stall;
    bit  fin, rdy;
    n = 0; c = 1; stall = 0; fin = 1'b0;
    @(negedge Clk); bus.Start = 1'b1;
    @(negedge Clk); bus.Start = 1'b0;
    while (!fin && c < 200) begin
      bus.Start = poke && (c == 2 || c == 3 || (n == 1 && c > 7));
      if (c <= 6) begin
        chk("scan_rd_en",  32'(bus.Rd_En), (c <= 5) ? 1 : 0);
        chk("scan_addr",   32'(bus.Rd_Addr), (c <= 5) ? c - 1 : 0);
        chk("scan_busy",   32'(bus.Busy), 1);
      end
      if (c == 7) chk("first_valid", 32'(bus.Out_Valid), 1);
      if (n == 3) begin
        chk("done_pulse", 32'(bus.Done), 1);
        chk("done_valid", 32'(bus.Out_Valid), 0);
        fin = 1'b1;
      end else begin
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = 1'($urandom_range(0, 1));
          default: rdy = !(n == 1 && stall < 4);
        endcase
        if (mode == 2 && n == 1 && !rdy) stall++;
        bus.Out_Ready = rdy;
        chk("no_early_done", 32'(bus.Done), 0);
        if (bus.Out_Valid) begin
          chk("out_rank",  32'(bus.Out_Rank), n);
          chk("out_id",    32'(bus.Out_ID), eid[n]);
          chk("out_score", 32'(bus.Out_Score), esc[n]);
          if (rdy) n++;
        end else begin
          chk("idle_rank",  32'(bus.Out_Rank), 0);
          chk("idle_id",    32'(bus.Out_ID), 0);
          chk("idle_score", 32'(bus.Out_Score), 0);
        end
      end
      @(negedge Clk);
      c++;
    end
    bus.Start = 1'b0;
    bus.Out_Ready = 1'b0;
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL scan_timeout got=%0d exp=3 entries", n);
    end
    chk("after_done",  32'(bus.Done), 0);
    chk("after_busy",  32'(bus.Busy), 0);
    @(negedge Clk);
    chk("no_queued_start", 32'(bus.Busy), 0);
  endtask

  initial begin
    int eid [3];
    int esc [3];
    int w;

    Reset = 1'b0;
    bus.Start = 1'b0;
    bus.Out_Ready = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = '0;

    add_vec(12, 40,  7, 40, 99,   4, 1, 3,   99,  40,  40,  0, 1'b1);
    add_vec( 0,  0,  0,  0,  0,   0, 1, 2,    0,   0,   0,  0, 1'b0);
    add_vec(127,127,127,127,127,  0, 1, 2,  127, 127, 127,  2, 1'b1);
    add_vec( 1,  2,  3,  4,  5,   4, 3, 2,    5,   4,   3,  1, 1'b0);
    add_vec(100, 90, 80, 70, 60,  0, 1, 2,  100,  90,  80,  2, 1'b0);
    add_vec( 5,127, 64, 63,127,   1, 4, 2,  127, 127,  64,  1, 1'b1);
    add_vec( 0,  0,  0,  0,  9,   4, 0, 1,    9,   0,   0,  0, 1'b0);

    repeat (2) @(negedge Clk);
    chk_idle_outputs("reset");
    Reset = 1'b1;
    @(negedge Clk);
    chk_idle_outputs("post_reset");

    foreach (vq[v]) begin
      for (int i = 0; i < 5; i++) mem[i] = 7'(vq[v].sc[i]);
      run_scan(vq[v].mode, vq[v].poke, vq[v].eid, vq[v].esc);
    end

    // Reset while rank 1 is on offer: nothing further may be emitted.
    for (int i = 0; i < 5; i++) mem[i] = 7'(vq[0].sc[i]);
    @(negedge Clk); bus.Start = 1'b1;
    @(negedge Clk); bus.Start = 1'b0;
    w = 0;
    while (!bus.Out_Valid && w < 20) begin
      @(negedge Clk);
      w++;
    end
    chk("mid_emit_reached", 32'(bus.Out_Valid), 1);
    bus.Out_Ready = 1'b1;
    @(negedge Clk);
    chk("mid_emit_rank1", 32'(bus.Out_Rank), 1);
    Reset = 1'b0;
    @(negedge Clk);
    chk_idle_outputs("mid_reset");
    Reset = 1'b1;
    repeat (3) begin
      @(negedge Clk);
      chk("abandoned_valid", 32'(bus.Out_Valid), 0);
      chk("abandoned_busy",  32'(bus.Busy), 0);
    end
    bus.Out_Ready = 1'b0;
    for (int i = 0; i < 5; i++) mem[i] = 7'(vq[3].sc[i]);
    model(eid, esc);
    run_scan(0, 1'b0, eid, esc);

    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 5; i++)
        mem[i] = (r % 2 == 1) ? 7'($urandom_range(0, 7)) : 7'($urandom_range(0, 127));
      model(eid, esc);
      run_scan(1, (r % 3) == 0, eid, esc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_reader.md
SCORE_READER -- requirements
Module: score_reader

Interface
REQ-001 Parameter NUM_PLAYERS, default 5, number of per-player best-score locations scanned (addresses 0..NUM_PLAYERS-1).
REQ-002 Parameter SCORE_W, default 7, score width in bits.
REQ-003 Parameter ID_W, default 3, player-ID and address width in bits.
REQ-004 Clk  input  1  clock; all state updates on rising edge.
REQ-005 Reset  input  1  reset, synchronous, active-low.
REQ-006 Start  input  1  request one leaderboard scan; sampled only in IDLE.
REQ-007 Busy  output  1  high in every state except IDLE.
REQ-008 Rd_En  output  1  read strobe to the score store.
REQ-009 Rd_Addr  output  ID_W  player location being read.
REQ-010 Rd_Data  input  SCORE_W  stored best score; valid exactly one cycle after the matching Rd_En.
REQ-011 Out_Valid  output  1  leaderboard entry available.
REQ-012 Out_Ready  input  1  consumer accepts entry when high with Out_Valid.
REQ-013 Out_Rank  output  2  entry rank, 0 = highest.
REQ-014 Out_ID  output  ID_W  player ID of entry.
REQ-015 Out_Score  output  SCORE_W  score of entry.
REQ-016 Done  output  1  one-cycle pulse after final entry accepted.

Function
REQ-017 FSM states SHALL be IDLE, SCAN, DRAIN, EMIT, DONE; unused encodings go to IDLE.
REQ-018 IDLE: Start=1 at edge k -> SCAN; Rd_En=1, Rd_Addr=0 registered, visible after edge k.
REQ-019 SCAN: Rd_En high for exactly NUM_PLAYERS consecutive cycles, Rd_Addr incrementing 0..NUM_PLAYERS-1; after last address -> DRAIN with Rd_En=0.
REQ-020 Each Rd_Data SHALL be captured one cycle after its Rd_En and tagged with that cycle's Rd_Addr via a one-stage pipeline register.
REQ-021 Each captured (ID, score) SHALL be inserted into a registered top-3 list; insertion only if score strictly greater than an occupant, so ties keep the lower (earlier) ID ahead.
REQ-022 Top-3 list SHALL clear to {ID 0, score 0} on every Start accepted.
REQ-023 DRAIN: captures the last Rd_Data, then -> EMIT; Out_Valid asserted the cycle after last capture.
REQ-024 EMIT: entries presented rank 0, 1, 2 in order; advance only on Out_Valid && Out_Ready.
REQ-025 While Out_Valid=1 and Out_Ready=0, Out_Rank, Out_ID, Out_Score SHALL hold stable.
REQ-026 Accepting rank 2 -> DONE: Out_Valid=0, Done=1 for one cycle, then IDLE.
REQ-027 Out_Ready=1 continuously SHALL give three entries on three consecutive cycles.
REQ-028 Start while Busy SHALL be ignored; no queuing.
REQ-029 Out_Rank/Out_ID/Out_Score SHALL be 0 whenever Out_Valid=0.
REQ-030 Score comparison unsigned, full SCORE_W; no arithmetic widening.
REQ-031 With NUM_PLAYERS < 3, unfilled ranks SHALL emit ID 0, score 0.

Reset
REQ-032 Reset=0 at an edge SHALL force IDLE, Busy=0, Rd_En=0, Rd_Addr=0, Out_Valid=0, Out_Rank/ID/Score=0, Done=0, top-3 list and pipeline cleared.
REQ-033 Reset SHALL take priority over Start and over any in-progress scan or emit; abandoned entries are never emitted.

Structure
REQ-034 Shared package score_pkg SHALL hold NUM_PLAYERS, SCORE_W, ID_W defaults, the FSM state enum, and the rank-entry type {ID, score}.
REQ-035 Sub-module score_rank_insert (combinational: current top-3 plus new entry -> next top-3) SHALL implement REQ-021.

Verification
REQ-036 Scores {0:12,1:40,2:7,3:40,4:99}, Start pulse, Out_Ready=1 -> entries (0,4,99),(1,1,40),(2,3,40), Done one cycle after third.
REQ-037 Rd_En timing: Start at edge k -> Rd_En high cycles k+1..k+5 addresses 0..4; first Out_Valid at cycle k+7.
REQ-038 Out_Ready low 4 cycles at rank 1 -> rank-1 entry held unchanged, no Done until all three accepted.
REQ-039 All scores 0 -> entries (0,0,0),(1,1,0),(2,2,0).
REQ-040 Start asserted during SCAN and EMIT -> ignored; Reset=0 mid-EMIT -> next cycle all outputs 0, IDLE, new Start rescans cleanly.
